// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing one imem request at a time, presenting the instruction or a NOP bubble to IF/ID
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [15:0] pc_plus4,
    output logic [31:0] inst,
    output logic        inst_valid
);
    typedef enum logic [1:0] {ISSUE, WAIT, PRESENT} state_t;
    state_t      state;
    logic [15:0] pc;
    logic [31:0] inst_q;
    logic        drop;
    logic [15:0] target;
    logic [15:0] pc_inc;
    assign target     = {redirect_pc[15:2], 2'b00};
    assign pc_inc     = pc + 16'd4;
    assign pc_plus4   = pc_inc;
    assign imem_req   = !rst && (state == ISSUE || (state == PRESENT && (redirect_valid || !stall)));
    assign imem_addr  = redirect_valid ? target : (state == PRESENT ? pc_inc : pc);
    assign inst_valid = !rst && state == PRESENT;
    assign inst       = inst_valid ? inst_q : NOP;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            state  <= ISSUE;
            drop   <= 1'b0;
            inst_q <= NOP;
        end else begin
            case (state)
                ISSUE: begin
                    if (redirect_valid) pc <= target;
                    state <= WAIT;
                end
                WAIT: begin
                    // A redirect while waiting orphans the in-flight word; drop remembers to discard it
                    if (imem_ack) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= ISSUE;
                            if (redirect_valid) pc <= target;
                        end else begin
                            inst_q <= imem_rdata;
                            state  <= PRESENT;
                        end
                    end else if (redirect_valid) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= WAIT;
                    end else if (!stall) begin
                        pc    <= pc_inc;
                        state <= WAIT;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks plus a memory model and a scoreboard of expected presentations
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [15:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    int errors = 0;
    int checks = 0;
    int lat = 1;
    logic [47:0] sb[$];

    fetch_unit #(.RESET_PC(16'h0040), .NOP(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_plus4(pc_plus4), .inst(inst), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0040) return 32'h2001_0005;
        if (a == 16'h0044) return 32'h2002_0007;
        return {~a, a};
    endfunction

    // memory: samples the request mid-cycle, answers lat cycles later for one cycle
    initial begin
        logic        pend;
        logic [15:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = 16'h0;
        cnt = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) pend = 1'b0;
            else if (imem_req) begin
                pend = 1'b1;
                paddr = imem_addr;
                cnt = lat;
            end
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (pend && !rst) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(paddr);
                    pend = 1'b0;
                end
            end
        end
    end

    // scoreboard: each new presentation must match the oldest expected entry
    initial begin
        logic        prev;
        logic [47:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (inst_valid && !prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL present_unexpected: got pc_plus4=%h inst=%h, required none", pc_plus4, inst);
                end else begin
                    exp = sb.pop_front();
                    if ({pc_plus4, inst} !== exp) begin
                        errors++;
                        $display("FAIL present: got pc_plus4=%h inst=%h, required pc_plus4=%h inst=%h",
                                 pc_plus4, inst, exp[47:32], exp[31:0]);
                    end
                end
            end
            prev = inst_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic wait_present(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            stall = 1'b1;
            #1;
            if (inst_valid) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: inst_valid=0, required 1 within 12 cycles", name);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({imem_req, inst_valid, inst, pc_plus4} !== {1'b0, 1'b0, 32'h0, 16'h0044}) begin
                errors++;
                $display("FAIL reset: got req=%b valid=%b inst=%h pc_plus4=%h, required 0 0 0 0044",
                         imem_req, inst_valid, inst, pc_plus4);
            end
        end
        sb.push_back({16'h0044, 32'h2001_0005});
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h, required 1 0040", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        #1;
        checks++;
        if ({imem_req, inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wait_cycle: got req=%b valid=%b, required 0 0", imem_req, inst_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            stall = 1'b1;
            #1;
            checks++;
            if ({inst_valid, inst, pc_plus4, imem_req} !== {1'b1, 32'h2001_0005, 16'h0044, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b inst=%h pc_plus4=%h req=%b, required 1 20010005 0044 0",
                         inst_valid, inst, pc_plus4, imem_req);
            end
        end
        sb.push_back({16'h0048, 32'h2002_0007});
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0044}) begin
            errors++;
            $display("FAIL stall_release: got req=%b addr=%h, required 1 0044", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        sb.push_back({16'h004C, mem_word(16'h0048)});
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({inst_valid, inst, pc_plus4, imem_req, imem_addr} !== {1'b1, 32'h2002_0007, 16'h0048, 1'b1, 16'h0048}) begin
            errors++;
            $display("FAIL seq_second: got valid=%b inst=%h pc_plus4=%h req=%b addr=%h, required 1 20020007 0048 1 0048",
                     inst_valid, inst, pc_plus4, imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        #1;
        checks++;
        if ({inst_valid, pc_plus4} !== {1'b1, 16'h004C}) begin
            errors++;
            $display("FAIL seq_third: got valid=%b pc_plus4=%h, required 1 004c", inst_valid, pc_plus4);
        end
    endtask

    task automatic test_redirect_present();
        sb.push_back({16'h0104, mem_word(16'h0100)});
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0100}) begin
            errors++;
            $display("FAIL redir_present_req: got req=%b addr=%h, required 1 0100", imem_req, imem_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_present_bubble: got valid=%b, required 0", inst_valid);
        end
        wait_present("redir_present");
    endtask

    task automatic test_redirect_wait();
        lat = 3;
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0104}) begin
            errors++;
            $display("FAIL redir_wait_req0: got req=%b addr=%h, required 1 0104", imem_req, imem_addr);
        end
        sb.push_back({16'h0204, mem_word(16'h0200)});
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({imem_ack, inst_valid, imem_req} !== 3'b100) begin
            errors++;
            $display("FAIL redir_wait_stale: got ack=%b valid=%b req=%b, required 1 0 0", imem_ack, inst_valid, imem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0200}) begin
            errors++;
            $display("FAIL redir_wait_reissue: got req=%b addr=%h, required 1 0200", imem_req, imem_addr);
        end
        wait_present("redir_wait");
    endtask

    task automatic test_redirect_with_ack();
        sb.push_back({16'h0304, mem_word(16'h0300)});
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0204}) begin
            errors++;
            $display("FAIL redir_ack_req0: got req=%b addr=%h, required 1 0204", imem_req, imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'h0300;
        #1;
        checks++;
        if ({imem_ack, imem_req} !== 2'b10) begin
            errors++;
            $display("FAIL redir_ack_same: got ack=%b req=%b, required 1 0", imem_ack, imem_req);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 16'h0300, 1'b0}) begin
            errors++;
            $display("FAIL redir_ack_reissue: got req=%b addr=%h valid=%b, required 1 0300 0", imem_req, imem_addr, inst_valid);
        end
        wait_present("redir_ack");
    endtask

    task automatic test_wrap();
        lat = 1;
        sb.push_back({16'h0000, mem_word(16'hFFFC)});
        sb.push_back({16'h0004, mem_word(16'h0000)});
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'hFFFC}) begin
            errors++;
            $display("FAIL wrap_redirect: got req=%b addr=%h, required 1 fffc", imem_req, imem_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        stall = 1'b0;
        #1;
        checks++;
        if ({inst_valid, pc_plus4, imem_req, imem_addr} !== {1'b1, 16'h0000, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_present: got valid=%b pc_plus4=%h req=%b addr=%h, required 1 0000 1 0000",
                     inst_valid, pc_plus4, imem_req, imem_addr);
        end
        wait_present("wrap_next");
    endtask

    initial begin
        test_reset();
        test_stall();
        test_sequential();
        test_redirect_present();
        test_redirect_wait();
        test_redirect_with_ack();
        test_wrap();
        @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
